board_manager: RTL and testbench

- Upstream of the game-control FSM: owns the Connect-4 board and accepts column drops.
- Places each piece in the lowest free row, then scans for four-in-a-row and board-full.
- Drives in_game_status, invalid_column and player_turn into the FSM as registered levels.

---
 rtl/board_manager.sv | 167 ++++++++++++++++
 tb/tb_board_manager.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_manager.sv
// board_manager: Connect-4 board owner sitting upstream of the game-control FSM.
// Accepts column drops, places each piece in the lowest free row, scans the four
// line directions through the new piece, and reports win / tie / next-turn.
//
// Ports:
//   clk, reset (async, active-low)    clock and reset
//   new_game                          synchronous clear, beats drop_valid
//   drop_valid, drop_col, drop_ready  column request handshake
//   game_status, status_valid         00 next turn, 01 win, 10 tie; one-cycle update pulse
//   invalid_column                    last request was out of range or to a full column
//   player_turn                       0 = P1 to move, 1 = P2 to move
//   rd_row, rd_col, rd_cell           display readback (00 empty, 01 P1, 10 P2)
//
// Optional feature: define BOARD_READBACK_EN to build the rd_cell read mux;
// otherwise rd_cell is tied to 00 and rd_row/rd_col are ignored.
module board_manager #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       drop_valid,
  input  logic [2:0] drop_col,
  output logic       drop_ready,
  output logic [1:0] game_status,
  output logic       status_valid,
  output logic       invalid_column,
  output logic       player_turn,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [1:0] rd_cell
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_PLACE  = 3'd2;
  localparam logic [2:0] S_SCAN   = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;
  localparam logic [2:0] S_LOCKED = 3'd5;

  localparam logic [6:0] CELLS = 7'(ROWS * COLS);

  // Storage is sized 8x8 so 3-bit row/col addresses index it directly;
  // only the ROWS x COLS corner is ever written.
  logic [2:0]            state;
  logic [7:0][7:0][1:0]  board;
  logic [7:0][3:0]       height;
  logic [6:0]            placed;
  logic [2:0]            col_q, row_q;
  logic                  bad_q;
  logic [1:0]            dir;
  logic                  win;

  logic [1:0] piece;
  int         run, dr, dc, r, c;
  logic       go_f, go_b, hit;

  assign drop_ready = (state == S_IDLE);
  // player_turn only changes in REPORT, so it still names the placed piece while scanning.
  assign piece = player_turn ? 2'b10 : 2'b01;

  // Run length through (row_q, col_q) along the direction selected by dir.
  always_comb begin
    dr = 1; dc = 0;
    case (dir)
      2'd0:    begin dr = 0; dc = 1;  end  // horizontal
      2'd1:    begin dr = 1; dc = 0;  end  // vertical
      2'd2:    begin dr = 1; dc = 1;  end  // diagonal /
      default: begin dr = 1; dc = -1; end  // diagonal, down-right
    endcase
    run  = 1;
    go_f = 1'b1;
    go_b = 1'b1;
    r    = 0;
    c    = 0;
    for (int k = 1; k < WIN_LEN; k++) begin
      r = int'(row_q) + k * dr;
      c = int'(col_q) + k * dc;
      if (go_f && r >= 0 && r < ROWS && c >= 0 && c < COLS && board[r[2:0]][c[2:0]] == piece)
        run++;
      else
        go_f = 1'b0;
      r = int'(row_q) - k * dr;
      c = int'(col_q) - k * dc;
      if (go_b && r >= 0 && r < ROWS && c >= 0 && c < COLS && board[r[2:0]][c[2:0]] == piece)
        run++;
      else
        go_b = 1'b0;
    end
    hit = (run >= WIN_LEN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;  board <= '0;  height <= '0;  placed <= '0;
      col_q <= '0;  row_q <= '0;  bad_q <= 1'b0;  dir <= '0;  win <= 1'b0;
      game_status <= 2'b00;  status_valid <= 1'b0;
      invalid_column <= 1'b0;  player_turn <= 1'b0;
    end else if (new_game) begin
      state <= S_IDLE;  board <= '0;  height <= '0;  placed <= '0;
      col_q <= '0;  row_q <= '0;  bad_q <= 1'b0;  dir <= '0;  win <= 1'b0;
      game_status <= 2'b00;  status_valid <= 1'b0;
      invalid_column <= 1'b0;  player_turn <= 1'b0;
    end else begin
      status_valid <= 1'b0;
      case (state)
        S_IDLE: if (drop_valid) begin
          col_q          <= drop_col;
          invalid_column <= 1'b0;
          state          <= S_CHECK;
        end
        // The legality check is registered here and acted on in PLACE, which
        // keeps the column-height lookup off the board write path.
        S_CHECK: begin
          bad_q <= ({1'b0, col_q} >= 4'(COLS)) || (height[col_q] == 4'(ROWS));
          row_q <= height[col_q][2:0];
          state <= S_PLACE;
        end
        S_PLACE: if (bad_q) begin
          invalid_column <= 1'b1;
          state          <= S_IDLE;
        end else begin
          board[row_q][col_q] <= piece;
          height[col_q]       <= height[col_q] + 4'd1;
          placed              <= placed + 7'd1;
          win                 <= 1'b0;
          dir                 <= 2'd0;
          state               <= S_SCAN;
        end
        // All four directions always run, giving a fixed report latency.
        S_SCAN: begin
          win <= win | hit;
          dir <= dir + 2'd1;
          if (dir == 2'd3) state <= S_REPORT;
        end
        S_REPORT: begin
          status_valid <= 1'b1;
          if (win) begin
            game_status <= 2'b01;
            state       <= S_LOCKED;
          end else if (placed == CELLS) begin
            game_status <= 2'b10;
            state       <= S_LOCKED;
          end else begin
            game_status <= 2'b00;
            player_turn <= ~player_turn;
            state       <= S_IDLE;
          end
        end
        S_LOCKED: ;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BOARD_READBACK_EN
  assign rd_cell = ({1'b0, rd_row} < 4'(ROWS) && {1'b0, rd_col} < 4'(COLS))
                   ? board[rd_row][rd_col] : 2'b00;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_row, rd_col};
  assign rd_cell   = 2'b00;
`endif

endmodule

// File: tb/tb_board_manager.sv
// Directed self-checking bench for board_manager.
module tb_board_manager;

  logic       clk = 1'b0;
  logic       reset, new_game, drop_valid;
  logic [2:0] drop_col, rd_row, rd_col;
  logic       drop_ready, status_valid, invalid_column, player_turn;
  logic [1:0] game_status, rd_cell;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  board_manager dut (
    .clk(clk), .reset(reset), .new_game(new_game),
    .drop_valid(drop_valid), .drop_col(drop_col), .drop_ready(drop_ready),
    .game_status(game_status), .status_valid(status_valid),
    .invalid_column(invalid_column), .player_turn(player_turn),
    .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell)
  );

  // Cell code expected from the readback port, or 00 when readback is not built.
  function automatic logic [1:0] rb(input logic [1:0] code);
`ifdef BOARD_READBACK_EN
    return code;
`else
    return 2'b00 & code;
`endif
  endfunction

  // Present a drop, then count edges until status_valid or invalid_column.
  task automatic do_drop(input logic [2:0] col, output int lat, output logic inv);
    drop_col = col; drop_valid = 1'b1;
    @(posedge clk); #1 drop_valid = 1'b0;
    lat = -1; inv = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (status_valid)   begin lat = i; break; end
      if (invalid_column) begin lat = i; inv = 1'b1; break; end
    end
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    @(posedge clk); #1 new_game = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; new_game = 1'b0; drop_valid = 1'b0; drop_col = 3'd0;
    rd_row = 3'd0; rd_col = 3'd0;
    repeat (3) @(posedge clk); #1;
    if ({drop_ready, game_status, status_valid, invalid_column, player_turn} !== 6'b100000) begin
      $display("FAIL reset_held: got %b want 100000",
               {drop_ready, game_status, status_valid, invalid_column, player_turn});
      n_bad++;
    end
    n_cmp++;
    reset = 1'b1;
    @(posedge clk); #1;
    if ({drop_ready, game_status, status_valid, invalid_column, player_turn} !== 6'b100000) begin
      $display("FAIL reset_released: got %b want 100000",
               {drop_ready, game_status, status_valid, invalid_column, player_turn});
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_single_drop();
    int lat; logic inv;
    do_drop(3'd3, lat, inv);
    if (lat !== 7 || inv !== 1'b0) begin
      $display("FAIL single_latency: got lat %0d inv %b want lat 7 inv 0", lat, inv); n_bad++;
    end
    n_cmp++;
    if (game_status !== 2'b00 || player_turn !== 1'b1) begin
      $display("FAIL single_status: got st %b turn %b want 00 1", game_status, player_turn); n_bad++;
    end
    n_cmp++;
    rd_row = 3'd0; rd_col = 3'd3;
    @(posedge clk); #1;
    if (status_valid !== 1'b0) begin
      $display("FAIL single_pulse_width: got sv %b want 0", status_valid); n_bad++;
    end
    n_cmp++;
    if (rd_cell !== rb(2'b01)) begin
      $display("FAIL single_cell03: got %b want %b", rd_cell, rb(2'b01)); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_new_game_mid_scan();
    logic seen_sv;
    drop_col = 3'd5; drop_valid = 1'b1;
    @(posedge clk); #1 drop_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 pulse_new_game();
    if ({drop_ready, game_status, status_valid, invalid_column, player_turn} !== 6'b100000) begin
      $display("FAIL midscan_clear: got %b want 100000",
               {drop_ready, game_status, status_valid, invalid_column, player_turn});
      n_bad++;
    end
    n_cmp++;
    seen_sv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (status_valid) seen_sv = 1'b1;
    end
    if (seen_sv !== 1'b0) begin
      $display("FAIL midscan_no_report: got sv seen %b want 0", seen_sv); n_bad++;
    end
    n_cmp++;
    rd_row = 3'd0; rd_col = 3'd3; #1;
    if (rd_cell !== 2'b00) begin
      $display("FAIL midscan_board_empty: got %b want 00", rd_cell); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_invalid_col();
    int lat; logic inv;
    do_drop(3'd7, lat, inv);
    if (lat !== 2 || inv !== 1'b1) begin
      $display("FAIL invalid_latency: got lat %0d inv %b want lat 2 inv 1", lat, inv); n_bad++;
    end
    n_cmp++;
    if (drop_ready !== 1'b1 || player_turn !== 1'b0 || game_status !== 2'b00) begin
      $display("FAIL invalid_hold: got rdy %b turn %b st %b want 1 0 00",
               drop_ready, player_turn, game_status); n_bad++;
    end
    n_cmp++;
    do_drop(3'd4, lat, inv);
    if (lat !== 7 || inv !== 1'b0 || invalid_column !== 1'b0) begin
      $display("FAIL invalid_clear: got lat %0d inv %b ic %b want 7 0 0", lat, inv, invalid_column);
      n_bad++;
    end
    n_cmp++;
    rd_row = 3'd0; rd_col = 3'd4; #1;
    if (rd_cell !== rb(2'b01) || player_turn !== 1'b1) begin
      $display("FAIL invalid_then_place: got cell %b turn %b want %b 1", rd_cell, player_turn, rb(2'b01));
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_column_full();
    int lat; logic inv; logic ok;
    pulse_new_game();
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_drop(3'd0, lat, inv);
      if (lat !== 7 || inv !== 1'b0 || game_status !== 2'b00) ok = 1'b0;
    end
    if (ok !== 1'b1 || player_turn !== 1'b0) begin
      $display("FAIL colfull_fill: got ok %b turn %b want 1 0", ok, player_turn); n_bad++;
    end
    n_cmp++;
    do_drop(3'd0, lat, inv);
    if (lat !== 2 || inv !== 1'b1 || player_turn !== 1'b0) begin
      $display("FAIL colfull_reject: got lat %0d inv %b turn %b want 2 1 0", lat, inv, player_turn);
      n_bad++;
    end
    n_cmp++;
    do_drop(3'd0, lat, inv);
    if (lat !== 2 || inv !== 1'b1) begin
      $display("FAIL colfull_reject2: got lat %0d inv %b want 2 1", lat, inv); n_bad++;
    end
    n_cmp++;
    do_drop(3'd1, lat, inv);
    if (lat !== 7 || inv !== 1'b0 || player_turn !== 1'b1) begin
      $display("FAIL colfull_retry: got lat %0d inv %b turn %b want 7 0 1", lat, inv, player_turn);
      n_bad++;
    end
    n_cmp++;
    rd_row = 3'd5; rd_col = 3'd0; #1;
    if (rd_cell !== rb(2'b10)) begin
      $display("FAIL colfull_top: got %b want %b", rd_cell, rb(2'b10)); n_bad++;
    end
    n_cmp++;
    rd_row = 3'd0; rd_col = 3'd1; #1;
    if (rd_cell !== rb(2'b01)) begin
      $display("FAIL colfull_retry_cell: got %b want %b", rd_cell, rb(2'b01)); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_vertical_win();
    int lat; logic inv; logic ok;
    logic [2:0] seq [7] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
    pulse_new_game();
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_drop(seq[i], lat, inv);
      if (lat !== 7 || inv !== 1'b0 || game_status !== 2'b00) ok = 1'b0;
    end
    if (ok !== 1'b1) begin
      $display("FAIL vwin_prelude: got ok %b want 1", ok); n_bad++;
    end
    n_cmp++;
    do_drop(seq[6], lat, inv);
    if (lat !== 7 || game_status !== 2'b01 || player_turn !== 1'b0 || drop_ready !== 1'b0) begin
      $display("FAIL vwin_report: got lat %0d st %b turn %b rdy %b want 7 01 0 0",
               lat, game_status, player_turn, drop_ready); n_bad++;
    end
    n_cmp++;
    drop_col = 3'd2; drop_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (status_valid !== 1'b0 || drop_ready !== 1'b0 || game_status !== 2'b01) ok = 1'b0;
    end
    drop_valid = 1'b0;
    if (ok !== 1'b1 || player_turn !== 1'b0) begin
      $display("FAIL vwin_locked: got ok %b turn %b want 1 0", ok, player_turn); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_diag_win();
    int lat; logic inv; logic ok;
    logic [2:0] seq [12] = '{3'd1, 3'd0, 3'd2, 3'd1, 3'd3, 3'd2,
                             3'd3, 3'd2, 3'd6, 3'd3, 3'd6, 3'd3};
    pulse_new_game();
    if ({drop_ready, game_status, status_valid, invalid_column, player_turn} !== 6'b100000) begin
      $display("FAIL dwin_unlock: got %b want 100000",
               {drop_ready, game_status, status_valid, invalid_column, player_turn});
      n_bad++;
    end
    n_cmp++;
    ok = 1'b1;
    for (int i = 0; i < 11; i++) begin
      do_drop(seq[i], lat, inv);
      if (lat !== 7 || inv !== 1'b0 || game_status !== 2'b00) ok = 1'b0;
    end
    if (ok !== 1'b1) begin
      $display("FAIL dwin_prelude: got ok %b want 1", ok); n_bad++;
    end
    n_cmp++;
    do_drop(seq[11], lat, inv);
    if (lat !== 7 || game_status !== 2'b01 || player_turn !== 1'b1 || drop_ready !== 1'b0) begin
      $display("FAIL dwin_report: got lat %0d st %b turn %b rdy %b want 7 01 1 0",
               lat, game_status, player_turn, drop_ready); n_bad++;
    end
    n_cmp++;
    rd_row = 3'd3; rd_col = 3'd3; #1;
    if (rd_cell !== rb(2'b10)) begin
      $display("FAIL dwin_cell33: got %b want %b", rd_cell, rb(2'b10)); n_bad++;
    end
    n_cmp++;
    pulse_new_game();
    if ({drop_ready, game_status, status_valid, invalid_column, player_turn} !== 6'b100000 ||
        rd_cell !== 2'b00) begin
      $display("FAIL dwin_newgame: got %b cell %b want 100000 00",
               {drop_ready, game_status, status_valid, invalid_column, player_turn}, rd_cell);
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_tie();
    int lat; logic inv; logic ok;
    logic [2:0] seq [42] = '{
      3'd2, 3'd0, 3'd0, 3'd2, 3'd2, 3'd0, 3'd0, 3'd2, 3'd2, 3'd0, 3'd0, 3'd2,
      3'd3, 3'd1, 3'd1, 3'd3, 3'd3, 3'd1, 3'd1, 3'd3, 3'd3, 3'd1, 3'd1, 3'd3,
      3'd6, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5,
      3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4,
      3'd6, 3'd6, 3'd6, 3'd6, 3'd6};
    pulse_new_game();
    ok = 1'b1;
    for (int i = 0; i < 41; i++) begin
      do_drop(seq[i], lat, inv);
      if (lat !== 7 || inv !== 1'b0 || game_status !== 2'b00) ok = 1'b0;
    end
    if (ok !== 1'b1 || player_turn !== 1'b1) begin
      $display("FAIL tie_prelude: got ok %b turn %b want 1 1", ok, player_turn); n_bad++;
    end
    n_cmp++;
    do_drop(seq[41], lat, inv);
    if (lat !== 7 || game_status !== 2'b10 || player_turn !== 1'b1 || drop_ready !== 1'b0) begin
      $display("FAIL tie_report: got lat %0d st %b turn %b rdy %b want 7 10 1 0",
               lat, game_status, player_turn, drop_ready); n_bad++;
    end
    n_cmp++;
    rd_row = 3'd5; rd_col = 3'd6; #1;
    if (rd_cell !== rb(2'b10)) begin
      $display("FAIL tie_last_cell: got %b want %b", rd_cell, rb(2'b10)); n_bad++;
    end
    n_cmp++;
    rd_row = 3'd6; rd_col = 3'd6; #1;
    if (rd_cell !== 2'b00) begin
      $display("FAIL tie_row_oor: got %b want 00", rd_cell); n_bad++;
    end
    n_cmp++;
    rd_row = 3'd0; rd_col = 3'd7; #1;
    if (rd_cell !== 2'b00) begin
      $display("FAIL tie_col_oor: got %b want 00", rd_cell); n_bad++;
    end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_single_drop();
    test_new_game_mid_scan();
    test_invalid_col();
    test_column_full();
    test_vertical_win();
    test_diag_win();
    test_tie();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
